// File: rtl/sda_drive_ctrl.sv
// -----------------------------------------------------------------------------
// sda_drive_ctrl
//
// Registered, glitch-free SDA output stage for the I2C slave datapath.
// The drive value selected by sda_mode/tx_out is applied to sda_out only while
// SCL is low. After each SCL falling edge the update waits HOLD_CYCLES clk
// cycles, which provides the data-hold time. In transmit mode the stage also
// watches the bus. If it releases SDA (sda_out = 1) while SCL is high and the
// bus reads back low, another master owns the bus. arb_lost then latches and
// forces the line released until STOP or idle mode.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on scl_in / sda_in (values below 2 are
//                raised to 2)
//   HOLD_CYCLES  clk cycles from detected SCL fall to sda_out update (0 ok)
//
// Ports
//   clk            system clock
//   n_rst          asynchronous active-low reset (releases the line at once)
//   scl_in         raw SCL bus level
//   sda_in         raw SDA bus level (readback)
//   sda_mode       00 idle release, 01 drive low, 10 release, 11 transmit
//   tx_out         serial transmit bit
//   stop_detected  one-cycle STOP pulse
//   sda_out        registered drive value (1 = release, 0 = pull low)
//   arb_lost       sticky arbitration-lost flag
//   hold_busy      high while the hold counter is running
// -----------------------------------------------------------------------------
module sda_drive_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic [1:0] sda_mode,
    input  logic       tx_out,
    input  logic       stop_detected,
    output logic       sda_out,
    output logic       arb_lost,
    output logic       hold_busy
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam bit HOLD_EN = (HOLD_CYCLES > 0);
    // The counter counts down to zero, so it is loaded with one less than
    // the hold length. With no hold the load value is never used.
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    typedef enum logic {
        STABLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [SYNC_N-1:0] scl_chain_reg;
    logic [SYNC_N-1:0] sda_chain_reg;
    logic              scl_prev_reg;
    logic              scl_sync;
    logic              sda_sync;
    logic              scl_fall;

    // The chains reset to 1 (bus idle). A bus that is low when reset is
    // released therefore shows up as a falling edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_chain_reg <= '1;
            sda_chain_reg <= '1;
            scl_prev_reg  <= 1'b1;
        end else begin
            scl_chain_reg <= {scl_chain_reg[SYNC_N-2:0], scl_in};
            sda_chain_reg <= {sda_chain_reg[SYNC_N-2:0], sda_in};
            scl_prev_reg  <= scl_chain_reg[SYNC_N-1];
        end
    end

    assign scl_sync = scl_chain_reg[SYNC_N-1];
    assign sda_sync = sda_chain_reg[SYNC_N-1];
    assign scl_fall = scl_prev_reg & ~scl_sync;

    // ------------------------------------------------------------ target
    logic sda_out_reg;
    logic sda_out_next;
    logic arb_lost_reg;
    logic arb_lost_next;
    logic target;

    always_comb begin
        target = 1'b1;
        if (!arb_lost_reg) begin
            case (sda_mode)
                2'b01:   target = 1'b0;
                2'b11:   target = tx_out;
                default: target = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------ FSM
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= STABLE;
            count_reg    <= '0;
            sda_out_reg  <= 1'b1;
            arb_lost_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            sda_out_reg  <= sda_out_next;
            arb_lost_reg <= arb_lost_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        sda_out_next = sda_out_reg;

        case (state_reg)
            STABLE: begin
                if (scl_fall && HOLD_EN) begin
                    state_next = HOLD;
                    count_next = HOLD_LOAD;
                end else if (!scl_sync) begin
                    // Covers both the zero-hold fall edge and late mode
                    // changes anywhere in the low phase.
                    sda_out_next = target;
                end
            end
            HOLD: begin
                if (scl_fall) begin
                    count_next = HOLD_LOAD;
                end else if (scl_sync) begin
                    // The low phase was shorter than the hold time. Drop
                    // the pending update so nothing moves while SCL is high.
                    state_next = STABLE;
                end else if (count_reg == '0) begin
                    sda_out_next = target;
                    state_next   = STABLE;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = STABLE;
            end
        endcase
    end

    // ------------------------------------------------------- arbitration
    logic arb_set;
    logic arb_clr;

    // The line is lost when we release SDA in transmit mode during SCL-high
    // but the bus reads low. Clearing takes priority over setting.
    assign arb_set = (sda_mode == 2'b11) && sda_out_reg && scl_sync && !sda_sync;
    assign arb_clr = stop_detected || (sda_mode == 2'b00);

    always_comb begin
        arb_lost_next = arb_lost_reg;
        if (arb_clr) begin
            arb_lost_next = 1'b0;
        end else if (arb_set) begin
            arb_lost_next = 1'b1;
        end
    end

    assign sda_out   = sda_out_reg;
    assign arb_lost  = arb_lost_reg;
    assign hold_busy = (state_reg == HOLD);

endmodule

// File: tb/tb_sda_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sda_drive_ctrl
//
// Runs two instances on shared stimulus. Index 0 uses HOLD_CYCLES = 3 and
// index 1 uses HOLD_CYCLES = 0. Directed scenarios check fixed expectations.
// A randomized phase compares both instances against a timestamp-based model
// of the drive rules.
// -----------------------------------------------------------------------------
module tb_sda_drive_ctrl;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       scl_in;
    logic       sda_in;
    logic [1:0] sda_mode;
    logic       tx_out;
    logic       stop_detected;
    logic [1:0] sda_out_w;
    logic [1:0] arb_w;
    logic [1:0] busy_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sda_drive_ctrl #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(3)) dut (
        .clk(clk), .n_rst(n_rst), .scl_in(scl_in), .sda_in(sda_in),
        .sda_mode(sda_mode), .tx_out(tx_out), .stop_detected(stop_detected),
        .sda_out(sda_out_w[0]), .arb_lost(arb_w[0]), .hold_busy(busy_w[0])
    );

    sda_drive_ctrl #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .scl_in(scl_in), .sda_in(sda_in),
        .sda_mode(sda_mode), .tx_out(tx_out), .stop_detected(stop_detected),
        .sda_out(sda_out_w[1]), .arb_lost(arb_w[1]), .hold_busy(busy_w[1])
    );

    // ------------------------------------------------------------ model
    // Synchronised levels come from a delay queue of raw samples. A pending
    // hold is represented as the absolute cycle number at which the update
    // becomes due (-1 = none).
    int hold_of [2] = '{3, 0};
    bit m_scl_q [$];
    bit m_sda_q [$];
    bit m_scl_prev;
    bit m_out [2];
    bit m_arb [2];
    int m_due [2];
    int cyc;

    function automatic void model_reset();
        m_scl_q = {};
        m_sda_q = {};
        for (int i = 0; i < SYNC; i++) begin
            m_scl_q.push_back(1'b1);
            m_sda_q.push_back(1'b1);
        end
        m_scl_prev = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_out[m] = 1'b1;
            m_arb[m] = 1'b0;
            m_due[m] = -1;
        end
        cyc = 0;
    endfunction

    function automatic void model_step();
        bit s_sync;
        bit d_sync;
        bit fall;
        bit tgt;
        bit set_c;
        bit clr_c;
        s_sync = m_scl_q[0];
        d_sync = m_sda_q[0];
        fall   = m_scl_prev && !s_sync;
        for (int m = 0; m < 2; m++) begin
            if (m_arb[m])             tgt = 1'b1;
            else if (sda_mode == 2'd1) tgt = 1'b0;
            else if (sda_mode == 2'd3) tgt = tx_out;
            else                       tgt = 1'b1;
            set_c = (sda_mode == 2'd3) && m_out[m] && s_sync && !d_sync;
            clr_c = stop_detected || (sda_mode == 2'd0);
            if (fall) begin
                if (hold_of[m] == 0) m_out[m] = tgt;
                else                 m_due[m] = cyc + hold_of[m];
            end else if (m_due[m] >= 0) begin
                if (s_sync) begin
                    m_due[m] = -1;
                end else if (cyc == m_due[m]) begin
                    m_out[m] = tgt;
                    m_due[m] = -1;
                end
            end else if (!s_sync) begin
                m_out[m] = tgt;
            end
            if (clr_c)      m_arb[m] = 1'b0;
            else if (set_c) m_arb[m] = 1'b1;
        end
        m_scl_prev = s_sync;
        m_scl_q.push_back(scl_in);
        m_sda_q.push_back(sda_in);
        void'(m_scl_q.pop_front());
        void'(m_sda_q.pop_front());
        cyc++;
    endfunction

    // One clock: inputs already stable from the previous negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        n_rst = 1'b0; sda_mode = 2'b01; scl_in = 1'b0; sda_in = 1'b1;
        tx_out = 1'b0; stop_detected = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (sda_out_w[m] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_sda_out[%0d]: got %b expected 1", m, sda_out_w[m]);
            end
            vectors++;
            if (arb_w[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_arb_lost[%0d]: got %b expected 0", m, arb_w[m]);
            end
            vectors++;
            if (busy_w[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold_busy[%0d]: got %b expected 0", m, busy_w[m]);
            end
        end
        n_rst = 1'b1;
        ticks(2);
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (sda_out_w[m] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_sync_latency[%0d]: got %b expected 1", m, sda_out_w[m]);
            end
        end
        ticks(6);
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (sda_out_w[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ack_low[%0d]: got %b expected 0", m, sda_out_w[m]);
            end
        end
    endtask

    task automatic test_hold_latency();
        sda_mode = 2'b11; tx_out = 1'b1;
        tick();
        scl_in = 1'b1;
        ticks(4);
        tx_out = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (sda_out_w[m] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL scl_high_hold[%0d] k=%0d: got %b expected 1", m, k, sda_out_w[m]);
                end
            end
        end
        scl_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (sda_out_w[0] !== ((k >= 6) ? 1'b0 : 1'b1)) begin
                miscompares++;
                $display("FAIL hold3_sda_out edge=%0d: got %b expected %b", k, sda_out_w[0], (k >= 6) ? 1'b0 : 1'b1);
            end
            vectors++;
            if (busy_w[0] !== ((k >= 3 && k <= 5) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL hold3_busy edge=%0d: got %b expected %b", k, busy_w[0], (k >= 3 && k <= 5) ? 1'b1 : 1'b0);
            end
            vectors++;
            if (sda_out_w[1] !== ((k >= 3) ? 1'b0 : 1'b1)) begin
                miscompares++;
                $display("FAIL hold0_sda_out edge=%0d: got %b expected %b", k, sda_out_w[1], (k >= 3) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_arbitration();
        tx_out = 1'b1;
        ticks(6);
        scl_in = 1'b1;
        ticks(4);
        sda_in = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (arb_w[m] !== ((k >= 3) ? 1'b1 : 1'b0)) begin
                    miscompares++;
                    $display("FAIL arb_set[%0d] edge=%0d: got %b expected %b", m, k, arb_w[m], (k >= 3) ? 1'b1 : 1'b0);
                end
            end
        end
        sda_in = 1'b1; tx_out = 1'b0;
        for (int p = 0; p < 2; p++) begin
            scl_in = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (k == 6) scl_in = 1'b1;
                tick();
                for (int m = 0; m < 2; m++) begin
                    vectors++;
                    if (sda_out_w[m] !== 1'b1 || arb_w[m] !== 1'b1) begin
                        miscompares++;
                        $display("FAIL arb_forced_release[%0d] p=%0d k=%0d: got out=%b arb=%b expected out=1 arb=1", m, p, k, sda_out_w[m], arb_w[m]);
                    end
                end
            end
        end
        stop_detected = 1'b1;
        tick();
        stop_detected = 1'b0;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (arb_w[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL arb_clear_stop[%0d]: got %b expected 0", m, arb_w[m]);
            end
        end
    endtask

    task automatic test_short_low();
        bit saw_busy;
        saw_busy = 1'b0;
        sda_mode = 2'b01;
        scl_in = 1'b0;
        ticks(2);
        scl_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (busy_w[0] === 1'b1) saw_busy = 1'b1;
            vectors++;
            if (sda_out_w[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL short_low_abort k=%0d: got %b expected 1", k, sda_out_w[0]);
            end
        end
        vectors++;
        if (saw_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL short_low_busy: got 0 expected 1");
        end
        vectors++;
        if (sda_out_w[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL short_low_hold0: got %b expected 0", sda_out_w[1]);
        end
        scl_in = 1'b0;
        ticks(8);
        vectors++;
        if (sda_out_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL full_low_ack: got %b expected 0", sda_out_w[0]);
        end
    endtask

    task automatic test_zero_hold();
        sda_mode = 2'b10;
        tick();
        scl_in = 1'b1;
        ticks(4);
        sda_mode = 2'b01;
        scl_in = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if (sda_out_w[1] !== ((k >= 3) ? 1'b0 : 1'b1)) begin
                miscompares++;
                $display("FAIL zero_hold_fall edge=%0d: got %b expected %b", k, sda_out_w[1], (k >= 3) ? 1'b0 : 1'b1);
            end
        end
        sda_mode = 2'b10;
        tick();
        vectors++;
        if (sda_out_w[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_hold_late_mode: got %b expected 1", sda_out_w[1]);
        end
    endtask

    task automatic test_async_reset();
        sda_mode = 2'b01;
        ticks(6);
        scl_in = 1'b1;
        ticks(4);
        scl_in = 1'b0;
        ticks(4);
        vectors++;
        if (busy_w[0] !== 1'b1 || sda_out_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset_hold: got busy=%b out=%b expected busy=1 out=0", busy_w[0], sda_out_w[0]);
        end
        #2;
        n_rst = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (sda_out_w[m] !== 1'b1 || busy_w[m] !== 1'b0 || arb_w[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset[%0d]: got out=%b busy=%b arb=%b expected 1/0/0", m, sda_out_w[m], busy_w[m], arb_w[m]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int scl_left;
        scl_left = $urandom_range(1, 8);
        for (int c = 0; c < 800; c++) begin
            if (scl_left == 0) begin
                scl_in   = ~scl_in;
                scl_left = $urandom_range(1, 8);
            end
            scl_left--;
            if ($urandom_range(0, 9) == 0) sda_mode = 2'($urandom_range(0, 3));
            tx_out        = 1'($urandom_range(0, 1));
            stop_detected = ($urandom_range(0, 39) == 0);
            sda_in        = m_out[0] & m_out[1] & ($urandom_range(0, 7) != 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (sda_out_w[m] !== m_out[m]) begin
                    miscompares++;
                    $display("FAIL rand_sda_out[%0d] cyc=%0d: got %b expected %b", m, cyc, sda_out_w[m], m_out[m]);
                end
                vectors++;
                if (arb_w[m] !== m_arb[m]) begin
                    miscompares++;
                    $display("FAIL rand_arb_lost[%0d] cyc=%0d: got %b expected %b", m, cyc, arb_w[m], m_arb[m]);
                end
                vectors++;
                if (busy_w[m] !== (m_due[m] >= 0)) begin
                    miscompares++;
                    $display("FAIL rand_hold_busy[%0d] cyc=%0d: got %b expected %b", m, cyc, busy_w[m], (m_due[m] >= 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_latency();
        test_arbitration();
        test_short_low();
        test_zero_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
